cpu_run_controller: RTL and testbench

//  Hardware harness sequencer for CPUTop: streams a program image into program

---
 rtl/cpu_run_controller.sv | 159 +++++++++++++++
 tb/tb_cpu_run_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Harness sequencer for CPUTop: loads program and data images through the tester
// ports, runs the CPU under a cycle watchdog, then streams data memory back out.
module cpu_run_controller #(
  parameter int PROG_WORDS = 256,
  parameter int DATA_WORDS = 1024,
  parameter int STEP_MAX   = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        finished,
  output logic        timeout,
  output logic [31:0] cycles,
  output logic        io_run,
  input  logic        io_done,
  output logic        io_testerProgMemEnable,
  output logic        io_testerProgMemWriteEnable,
  output logic [15:0] io_testerProgMemAddress,
  output logic [31:0] io_testerProgMemDataWrite,
  output logic        io_testerDataMemEnable,
  output logic        io_testerDataMemWriteEnable,
  output logic [15:0] io_testerDataMemAddress,
  output logic [31:0] io_testerDataMemDataWrite,
  input  logic [31:0] io_testerDataMemDataRead
);

  typedef enum logic [2:0] {
    IDLE, LOAD_PROG, LOAD_DATA, RUN, DUMP_RD, DUMP_OUT, FINISH
  } state_t;

  localparam logic [15:0] PROG_LAST = 16'(PROG_WORDS - 1);
  localparam logic [15:0] DATA_LAST = 16'(DATA_WORDS - 1);
  localparam logic [31:0] STEP_LIM  = 32'(STEP_MAX);

  state_t      state, state_nx;
  logic [15:0] addr;
  logic [31:0] out_q;
  logic        dump_first;
  logic        xfer, out_hs, wd_hit, run_exit, sess_start;
  logic [31:0] cyc_inc;

  assign xfer       = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign cyc_inc    = (&cycles) ? cycles : cycles + 32'd1;
  assign wd_hit     = cyc_inc >= STEP_LIM;
  assign run_exit   = io_done || wd_hit;
  assign sess_start = start && (state == IDLE || state == FINISH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FINISH: if (start) state_nx = LOAD_PROG;
      LOAD_PROG:    if (xfer && addr == PROG_LAST) state_nx = LOAD_DATA;
      LOAD_DATA:    if (xfer && addr == DATA_LAST) state_nx = RUN;
      RUN:          if (run_exit) state_nx = DUMP_RD;
      DUMP_RD:      state_nx = DUMP_OUT;
      DUMP_OUT:     if (out_hs) state_nx = (addr == DATA_LAST) ? FINISH : DUMP_RD;
      default:      state_nx = IDLE;
    endcase
  end

  // Memory read data is only valid in the first DUMP_OUT cycle, so it is passed
  // straight through then and held in out_q for any stalled cycles after.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      cycles     <= '0;
      timeout    <= 1'b0;
      out_q      <= '0;
      dump_first <= 1'b0;
    end else begin
      dump_first <= (state == DUMP_RD);
      if (sess_start) begin
        addr    <= '0;
        cycles  <= '0;
        timeout <= 1'b0;
      end
      case (state)
        LOAD_PROG: if (xfer) addr <= (addr == PROG_LAST) ? 16'd0 : addr + 16'd1;
        LOAD_DATA: if (xfer) addr <= (addr == DATA_LAST) ? 16'd0 : addr + 16'd1;
        RUN: begin
          cycles <= cyc_inc;
          if (run_exit) addr <= '0;
          if (!io_done && wd_hit) timeout <= 1'b1;
        end
        DUMP_OUT: begin
          if (dump_first) out_q <= io_testerDataMemDataRead;
          if (out_hs && addr != DATA_LAST) addr <= addr + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready                    = 1'b0;
    out_valid                   = 1'b0;
    out_data                    = out_q;
    busy                        = 1'b1;
    finished                    = 1'b0;
    io_run                      = 1'b0;
    io_testerProgMemEnable      = 1'b0;
    io_testerProgMemWriteEnable = 1'b0;
    io_testerProgMemAddress     = '0;
    io_testerProgMemDataWrite   = '0;
    io_testerDataMemEnable      = 1'b0;
    io_testerDataMemWriteEnable = 1'b0;
    io_testerDataMemAddress     = '0;
    io_testerDataMemDataWrite   = '0;
    case (state)
      IDLE: busy = 1'b0;
      FINISH: begin
        busy     = 1'b0;
        finished = 1'b1;
      end
      LOAD_PROG: begin
        in_ready = 1'b1;
        if (in_valid) begin
          io_testerProgMemEnable      = 1'b1;
          io_testerProgMemWriteEnable = 1'b1;
          io_testerProgMemAddress     = addr;
          io_testerProgMemDataWrite   = in_data;
        end
      end
      LOAD_DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          io_testerDataMemEnable      = 1'b1;
          io_testerDataMemWriteEnable = 1'b1;
          io_testerDataMemAddress     = addr;
          io_testerDataMemDataWrite   = in_data;
        end
      end
      RUN: io_run = 1'b1;
      DUMP_RD: begin
        io_testerDataMemEnable  = 1'b1;
        io_testerDataMemAddress = addr;
      end
      DUMP_OUT: begin
        out_valid = 1'b1;
        if (dump_first) out_data = io_testerDataMemDataRead;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller with a small tester-memory model
// standing in for CPUTop (sync-read data memory, one store while running).
module tb_cpu_run_controller;
  localparam int P = 4, D = 4, S = 50;
  localparam int SLOT = 2;

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;

  logic clock = 0, reset = 0, start = 0, in_valid = 0, out_ready = 0, io_done = 0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, busy, finished, timeout, io_run;
  logic [31:0] out_data, cycles;
  logic pm_en, pm_we, dm_en, dm_we;
  logic [15:0] pm_a, dm_a;
  logic [31:0] pm_d, dm_d, dm_rd;

  cpu_run_controller #(.PROG_WORDS(P), .DATA_WORDS(D), .STEP_MAX(S)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .finished(finished), .timeout(timeout), .cycles(cycles),
    .io_run(io_run), .io_done(io_done),
    .io_testerProgMemEnable(pm_en), .io_testerProgMemWriteEnable(pm_we),
    .io_testerProgMemAddress(pm_a), .io_testerProgMemDataWrite(pm_d),
    .io_testerDataMemEnable(dm_en), .io_testerDataMemWriteEnable(dm_we),
    .io_testerDataMemAddress(dm_a), .io_testerDataMemDataWrite(dm_d),
    .io_testerDataMemDataRead(dm_rd)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0, n_dump = 0;
  wr_t exp_pw[$], exp_dw[$];
  logic [31:0] exp_dump[$];
  logic [31:0] dmem [0:D-1];
  logic [31:0] cpu_val = '0;
  logic [31:0] sess_data [0:D-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Tester memory model: sync read, garbage on the read port when not enabled,
  // and a "CPU" store into SLOT every run cycle.
  always @(posedge clock) begin
    if (dm_en && dm_we && dm_a < 16'(D)) dmem[dm_a] <= dm_d;
    if (dm_en && !dm_we) dm_rd <= (dm_a < 16'(D)) ? dmem[dm_a] : 32'hDEAD_BEEF;
    else                 dm_rd <= $urandom;
    if (io_run) dmem[SLOT] <= cpu_val;
  end

  logic        prev_hold = 0;
  logic [31:0] held = '0;
  always @(negedge clock) begin
    wr_t w;
    if (pm_en) begin
      chk("pw_expected", 32'(exp_pw.size() > 0), 1);
      chk("pw_we", {31'd0, pm_we}, 1);
      if (exp_pw.size() > 0) begin
        w = exp_pw.pop_front();
        chk("pw_addr", {16'd0, pm_a}, {16'd0, w.a});
        chk("pw_data", pm_d, w.d);
      end
    end
    if (dm_en && dm_we) begin
      chk("dw_expected", 32'(exp_dw.size() > 0), 1);
      if (exp_dw.size() > 0) begin
        w = exp_dw.pop_front();
        chk("dw_addr", {16'd0, dm_a}, {16'd0, w.a});
        chk("dw_data", dm_d, w.d);
      end
    end
    if (io_run) begin
      chk("rdy_in_run", {31'd0, in_ready}, 0);
      chk("en_in_run", {30'd0, pm_en, dm_en}, 0);
    end
    if (prev_hold) begin
      chk("hold_vld", {31'd0, out_valid}, 1);
      chk("hold_data", out_data, held);
    end
    if (out_valid && out_ready) begin
      chk("dump_expected", 32'(exp_dump.size() > 0), 1);
      if (exp_dump.size() > 0) chk("dump_data", out_data, exp_dump.pop_front());
      n_dump++;
    end
    prev_hold = out_valid && !out_ready;
    held      = out_data;
  end

  task automatic begin_session(input int sess);
    @(posedge clock); #1 start = 1;
    @(posedge clock); #1 start = 0;
    chk("busy_load", {31'd0, busy}, 1);
    chk("cycles_clr", cycles, 0);
    n_dump  = 0;
    cpu_val = 32'hC0DE_0000 + 32'(sess);
  endtask

  task automatic load_stream(input int sess, input bit toggle, input bit pulse);
    bit acc;
    int n;
    for (int i = 0; i < P + D; i++) begin
      if (i < P) begin
        in_data = 32'h1000_0000 + 32'(sess << 8) + 32'(i);
        exp_pw.push_back('{a: 16'(i), d: in_data});
      end else begin
        in_data = $urandom;
        sess_data[i-P] = in_data;
        exp_dw.push_back('{a: 16'(i-P), d: in_data});
      end
      if (pulse && i == P + 1) start = 1;
      acc = 0; n = 0;
      while (!acc && n < 100) begin
        in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clock); acc = in_valid && in_ready;
        @(posedge clock); #1 start = 0; n++;
      end
      chk("load_accept", {31'd0, acc}, 1);
    end
    in_valid = 0;
  endtask

  // Returns early (with reset pulsed) when abort_at matches the run cycle.
  task automatic run_phase(input int done_at, input bit pulse, input bit vld_in,
                           input int exp_cnt, input int abort_at);
    int k = 0, n = 0;
    chk("run_entry", {31'd0, io_run}, 1);
    if (done_at == 1) io_done = 1;
    while (n < 400) begin
      @(negedge clock); n++;
      if (!io_run) break;
      k++;
      if (k == done_at) io_done = 1;
      start = pulse && k == 3;
      if (vld_in) in_valid = 1;
      if (k == abort_at) begin
        #2 reset = 0;
        #1;
        chk("abort_run", {31'd0, io_run}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_en", {28'd0, pm_en, pm_we, dm_en, dm_we}, 0);
        chk("abort_cycles", cycles, 0);
        start = 0; in_valid = 0;
        @(posedge clock); #1 reset = 1;
        return;
      end
    end
    io_done = 0; in_valid = 0; start = 0;
    chk("run_cnt", 32'(k), 32'(exp_cnt));
    for (int i = 0; i < D; i++) exp_dump.push_back(i == SLOT ? cpu_val : sess_data[i]);
  endtask

  task automatic dump_phase(input bit stall, input int exp_cyc, input bit exp_to);
    int n = 0;
    bit stalled = 0;
    out_ready = 1;
    while (!finished && n < 300) begin
      @(posedge clock); #1 n++;
      if (stall && !stalled && n_dump >= 2) begin
        out_ready = 0;
        repeat (20) @(posedge clock);
        #1 out_ready = 1;
        stalled = 1;
      end
    end
    chk("finished", {31'd0, finished}, 1);
    chk("busy_fin", {31'd0, busy}, 0);
    chk("dump_left", 32'(exp_dump.size()), 0);
    chk("dump_count", 32'(n_dump), D);
    chk("cycles", cycles, 32'(exp_cyc));
    chk("timeout", {31'd0, timeout}, {31'd0, exp_to});
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_watchdog act=running exp=finished");
    $fatal(1, "bench watchdog");
  end

  initial begin
    #12;
    chk("rst_outs", {24'd0, busy, finished, timeout, io_run, in_ready, out_valid, pm_en, dm_en}, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clock); #1 reset = 1;
    chk("idle_busy", {31'd0, busy}, 0);

    // basic session, start pulsed in LOAD_DATA and RUN, in_valid high in RUN
    begin_session(1);
    load_stream(1, 0, 1);
    run_phase(10, 1, 1, 10, 0);
    dump_phase(0, 10, 0);

    // watchdog, toggled in_valid, stalled dump
    begin_session(2);
    load_stream(2, 1, 0);
    run_phase(0, 0, 0, S, 0);
    dump_phase(1, S, 1);

    // io_done coincides with watchdog
    begin_session(3);
    load_stream(3, 0, 0);
    run_phase(S, 0, 0, S, 0);
    dump_phase(0, S, 0);

    // io_done already high on RUN entry
    begin_session(4);
    load_stream(4, 1, 0);
    run_phase(1, 0, 0, 1, 0);
    dump_phase(0, 1, 0);

    // reset in the middle of RUN, then a clean session
    begin_session(5);
    load_stream(5, 0, 0);
    run_phase(0, 0, 0, 0, 5);
    exp_pw.delete(); exp_dw.delete(); exp_dump.delete();
    chk("post_rst_fin", {31'd0, finished}, 0);
    begin_session(6);
    load_stream(6, 1, 0);
    run_phase(7, 0, 0, 7, 0);
    dump_phase(1, 7, 0);

    chk("pw_left", 32'(exp_pw.size()), 0);
    chk("dw_left", 32'(exp_dw.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
